// File: rtl/cell4_vector_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cell4_pkg
// Description : Shared types and constants for the 4-input cell vector driver:
//               FSM state encoding, vector width and common truth tables.
// Revision    : 1.0 - initial release
// ============================================================================
package cell4_pkg;

    localparam int VEC_W = 4;
    localparam int ERR_W = 5;

    // Expected ZN indexed by {A1,A2,A3,A4}
    localparam logic [15:0] TRUTH_NOR4  = 16'h0001;
    localparam logic [15:0] TRUTH_NAND4 = 16'h7FFF;
    localparam logic [15:0] TRUTH_AND4  = 16'h8000;
    localparam logic [15:0] TRUTH_OR4   = 16'hFFFE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cell4_vector_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : cell4_vector_driver_if
// Description : Bundle between the vector driver, the cell under test and the
//               bench: start request, cell stimulus/response and run results.
// Revision    : 1.0 - initial release
// ============================================================================
interface cell4_vector_driver_if;
    import cell4_pkg::*;

    logic             start;
    logic             ZN;
    logic             A1;
    logic             A2;
    logic             A3;
    logic             A4;
    logic             busy;
    logic             done;
    logic             pass;
    logic             sample_valid;
    logic [VEC_W-1:0] sample_vec;
    logic             sample_zn;
    logic [ERR_W-1:0] err_count;
    logic             fail_seen;
    logic [VEC_W-1:0] first_fail;

    // Driver side
    modport master (
        input  start, ZN,
        output A1, A2, A3, A4, busy, done, pass, sample_valid, sample_vec,
               sample_zn, err_count, fail_seen, first_fail
    );

    // Bench / cell side
    modport slave (
        output start, ZN,
        input  A1, A2, A3, A4, busy, done, pass, sample_valid, sample_vec,
               sample_zn, err_count, fail_seen, first_fail
    );

endinterface
`default_nettype wire

// File: rtl/cell4_vector_driver_resp_checker.sv
`default_nettype none
// ============================================================================
// Module      : cell4_resp_checker
// Description : Compares the sampled ZN against the truth table, keeps the
//               saturating mismatch count, captures the first failing vector
//               and registers the per-sample trace outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module cell4_resp_checker
    import cell4_pkg::*;
#(
    parameter logic [15:0] TRUTH = TRUTH_NOR4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sample_en,
    input  logic [VEC_W-1:0] vec,
    input  logic             zn,
    output logic             sample_valid,
    output logic [VEC_W-1:0] sample_vec,
    output logic             sample_zn,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_seen,
    output logic [VEC_W-1:0] first_fail,
    output logic             run_clean
);

    localparam logic [ERR_W-1:0] c_ERR_MAX = 5'd16;

    logic             r_sample_valid;
    logic [VEC_W-1:0] r_sample_vec;
    logic             r_sample_zn;
    logic [ERR_W-1:0] r_err_count;
    logic             r_fail_seen;
    logic [VEC_W-1:0] r_first_fail;

    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_nxt;

    // Case inequality so an X or Z response is scored as a failure; the
    // mismatch is not gated by sample_en, which keeps run_clean free of any
    // combinational path back into the controller.
    always_comb begin
        w_mismatch = (zn !== TRUTH[vec]);
        w_err_nxt  = r_err_count;
        if (w_mismatch && (r_err_count != c_ERR_MAX)) begin
            w_err_nxt = r_err_count + 5'd1;
        end
        run_clean  = (r_err_count == '0) && !w_mismatch;
    end

    // Sample trace, error count and first-fail capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_valid <= 1'b0;
            r_sample_vec   <= '0;
            r_sample_zn    <= 1'b0;
            r_err_count    <= '0;
            r_fail_seen    <= 1'b0;
            r_first_fail   <= '0;
        end else begin
            r_sample_valid <= sample_en;
            if (clear) begin
                r_sample_vec <= '0;
                r_sample_zn  <= 1'b0;
                r_err_count  <= '0;
                r_fail_seen  <= 1'b0;
                r_first_fail <= '0;
            end else if (sample_en) begin
                r_sample_vec <= vec;
                r_sample_zn  <= zn;
                r_err_count  <= w_err_nxt;
                if (w_mismatch && !r_fail_seen) begin
                    r_fail_seen  <= 1'b1;
                    r_first_fail <= vec;
                end
            end
        end
    end

    assign sample_valid = r_sample_valid;
    assign sample_vec   = r_sample_vec;
    assign sample_zn    = r_sample_zn;
    assign err_count    = r_err_count;
    assign fail_seen    = r_fail_seen;
    assign first_fail   = r_first_fail;

endmodule
`default_nettype wire

// File: rtl/cell4_vector_driver.sv
`default_nettype none
// ============================================================================
// Module      : cell4_vector_driver
// Description : Walks all 16 input combinations of a 4-input cell in binary
//               order, holds each for a settle window, samples ZN and scores
//               it against a truth table.
// Revision    : 1.0 - initial release
// ============================================================================
module cell4_vector_driver
    import cell4_pkg::*;
#(
    parameter int          SETTLE = 10,
    parameter int          GAP    = 5,
    parameter logic [15:0] TRUTH  = TRUTH_NOR4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cell4_vector_driver_if.master   bus
);

    // Counter must hold whichever of the settle or gap reload is larger
    localparam int c_CNT_MAX = (SETTLE > GAP) ? SETTLE : GAP;
    localparam int c_CNT_W   = (c_CNT_MAX < 2) ? 1 : $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_SETTLE_LD = c_CNT_W'(SETTLE);
    localparam logic [c_CNT_W-1:0] c_GAP_LD    = c_CNT_W'(GAP);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [VEC_W-1:0]   c_VEC_LAST  = 4'hF;

    state_t             r_state;
    logic [VEC_W-1:0]   r_vec;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;

    state_t             w_state_nxt;
    logic [VEC_W-1:0]   w_vec_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_pass_nxt;
    logic               w_sample_en;
    logic               w_clear;
    logic               w_run_clean;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    // Next-state logic: a count of 1 marks the last cycle of a settle or gap
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        w_sample_en = 1'b0;
        w_clear     = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_nxt = DRIVE;
                    w_vec_nxt   = '0;
                    w_cnt_nxt   = c_SETTLE_LD;
                    w_clear     = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                end
            end
            DRIVE: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_sample_en = 1'b1;
                    if (r_vec == c_VEC_LAST) begin
                        w_state_nxt = DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = w_run_clean;
                    end else if (GAP > 0) begin
                        w_state_nxt = HOLD;
                        w_cnt_nxt   = c_GAP_LD;
                    end else begin
                        w_vec_nxt   = r_vec + 4'd1;
                        w_cnt_nxt   = c_SETTLE_LD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            HOLD: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_state_nxt = DRIVE;
                    w_vec_nxt   = r_vec + 4'd1;
                    w_cnt_nxt   = c_SETTLE_LD;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    cell4_resp_checker #(
        .TRUTH (TRUTH)
    ) u_checker (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (w_clear),
        .sample_en    (w_sample_en),
        .vec          (r_vec),
        .zn           (bus.ZN),
        .sample_valid (bus.sample_valid),
        .sample_vec   (bus.sample_vec),
        .sample_zn    (bus.sample_zn),
        .err_count    (bus.err_count),
        .fail_seen    (bus.fail_seen),
        .first_fail   (bus.first_fail),
        .run_clean    (w_run_clean)
    );

    // A1 is the MSB of the vector index
    assign bus.A1   = r_vec[3];
    assign bus.A2   = r_vec[2];
    assign bus.A3   = r_vec[1];
    assign bus.A4   = r_vec[0];
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.pass = r_pass;

endmodule
`default_nettype wire
